pmcd_release_ctrl: RTL
======================

// Module: pmcd_release_ctrl
// PURPOSE
//  Sequencer driving the RST and REL inputs of a phase-matched clock divider (PMCD).
//  Holds the PMCD in reset until the upstream DCM reports a stable lock.
//  It then releases reset, asserts REL, and checks that a divided-clock feedback toggles.
//  Sits in the clock-management wrapper between the DCM and the PMCD; READY gates downstream logic.
// PARAMETERS
//  RST_HOLD_CYCLES     16      min cycles PMCD_RST held high on each (re)entry to HOLD (>=1)
//  LOCK_STABLE_CYCLES  64      consecutive synced-lock cycles required before reset release
//  REL_DELAY_CYCLES    8       cycles from PMCD_RST deassert to PMCD_REL assert
//  FB_TIMEOUT_CYCLES   256     cycles allowed in CHECK to see 2 FB_DIV edges
//  MAX_RETRIES         3       failed CHECK attempts before sticky FAULT (1..15)
//  EN_REL              "TRUE"  "FALSE": PMCD_REL never asserted; REL_WAIT goes straight to CHECK
// PORTS
//  CLK         in   1  free-running system clock; all logic on rising edge
//  RST         in   1  synchronous, active-high reset
//  DCM_LOCKED  in   1  DCM lock (asynchronous); 2-FF synchronized internally
//  FB_DIV      in   1  divided-clock feedback, e.g. CLKA1D8 (asynchronous); 2-FF synchronized
//  PMCD_RST    out  1  drives PMCD RST, registered
//  PMCD_REL    out  1  drives PMCD REL, registered, level (held while running)
//  READY       out  1  clocks verified; registered
//  FAULT       out  1  sticky retry exhaustion; cleared only by RST
//  RETRY_CNT   out  4  failed CHECK attempts since last RUN entry
//  STATE       out  3  current FSM state (debug)
// BEHAVIOUR
//  Reset (RST=1 at edge): PMCD_RST=1, PMCD_REL=0, READY=0, FAULT=0, RETRY_CNT=0.
//   Reset also sets state=HOLD, counter=0, and clears the synchronizer and edge-detect flops to 0.
//  lock_s / fb_s = 2-FF synced inputs. An input change acts on the 3rd rising edge.
//   fb_edge = fb_s XOR its previous value (both edges count).
//  States (encoding 0..6): HOLD, WAIT_LOCK, STABLE, REL_WAIT, CHECK, RUN, FAULT.
//  HOLD: PMCD_RST=1, REL=0, READY=0. After RST_HOLD_CYCLES cycles -> WAIT_LOCK.
//  WAIT_LOCK: PMCD_RST=1. lock_s=1 -> STABLE with counter cleared.
//  STABLE: lock_s=0 -> WAIT_LOCK. After LOCK_STABLE_CYCLES consecutive lock_s=1 cycles:
//   PMCD_RST<=0 and -> REL_WAIT.
//  REL_WAIT: after REL_DELAY_CYCLES, PMCD_REL<=1 (only if EN_REL="TRUE") and -> CHECK.
//  CHECK: edge counter clears on entry.
//   2nd fb_edge before FB_TIMEOUT_CYCLES elapse -> RUN, READY<=1, RETRY_CNT<=0.
//   Timeout with RETRY_CNT+1==MAX_RETRIES -> FAULT.
//   Timeout otherwise -> RETRY_CNT++ and -> HOLD.
//   Timeout and 2nd edge on the same cycle: the edge wins.
//  RUN: outputs steady. lock_s=0 -> HOLD; next edge gives PMCD_RST=1, REL=0, READY=0.
//   A lock drop in RUN does not increment RETRY_CNT.
//  Lock drop in REL_WAIT or CHECK -> HOLD; reset is reasserted, no retry increment.
//  FAULT: PMCD_RST=1, REL=0, READY=0, FAULT=1. Terminal until RST.
//  Counter: one shared down/up counter, width clog2(max parameter)+1. No wrap is ever reached.
//   The counter reloads on every state change.
//  RST mid-sequence from any state: all outputs take reset values on that same edge.
// STRUCTURE
//  Shared include pmcd_ctrl_defs.vh holds the state-encoding localparams and a clog2 function.
//  Sub-module pmcd_sync2: 2-FF synchronizer with sync reset, instantiated twice.
//  Top holds the FSM, the shared counter, the edge counter and the retry counter.
//   Expected size ~200 lines.
// TESTING
//  T1 Normal bring-up: RST 4 cycles; DCM_LOCKED=1 at cycle 10; FB_DIV toggles every 8 cycles.
//   -> PMCD_RST falls 64 cycles after STABLE entry; PMCD_REL rises exactly 8 cycles later.
//   -> READY=1 after the 2nd synced FB edge; RETRY_CNT=0.
//  T2 Lock glitch: DCM_LOCKED drops 1 cycle at STABLE count 40 -> returns to WAIT_LOCK.
//   -> The stable count restarts; PMCD_RST stays 1 throughout.
//  T3 Dead feedback: FB_DIV held 0 -> 3 CHECK timeouts of 256 cycles each.
//   -> RETRY_CNT goes 1, then 2, then FAULT=1; PMCD_RST=1 and REL=0 thereafter.
//  T4 Lock loss in RUN: DCM_LOCKED->0.
//   -> 3rd edge after the change: PMCD_RST=1, REL=0, READY=0, state=HOLD.
//   -> Relock repeats the T1 sequence.
//  T5 EN_REL="FALSE": T1 stimulus -> PMCD_REL stays 0 throughout; READY still reaches 1.
//  T6 RST asserted in CHECK and in FAULT -> all outputs at reset values on the next edge; FAULT cleared.

Source files
------------

// File: rtl/pmcd_release_ctrl_pkg.sv
// Shared definitions for the PMCD release sequencer: state encoding and
// elaboration-time sizing helpers.
package pmcd_release_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_WAIT  = 3'd3,
        ST_CHECK     = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } pmcd_state_t;

    localparam int RETRY_W = 4;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pmcd_release_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous level input; both flops clear on
// the synchronous reset so the synced value starts from a known 0.
module pmcd_release_ctrl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pmcd_release_ctrl.sv
// Sequencer for the PMCD RST/REL pins: holds the divider in reset until the DCM
// lock is stable, releases it, then verifies the divided-clock feedback toggles.
module pmcd_release_ctrl
    import pmcd_release_ctrl_pkg::*;
#(
    parameter int    RST_HOLD_CYCLES    = 16,
    parameter int    LOCK_STABLE_CYCLES = 64,
    parameter int    REL_DELAY_CYCLES   = 8,
    parameter int    FB_TIMEOUT_CYCLES  = 256,
    parameter int    MAX_RETRIES        = 3,
    parameter string EN_REL             = "TRUE"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dcm_locked,
    input  logic               fb_div,
    output logic               pmcd_rst,
    output logic               pmcd_rel,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    localparam int CNT_W = clog2(max4(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                      REL_DELAY_CYCLES, FB_TIMEOUT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REL_LAST     = CNT_W'(REL_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(FB_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam bit                 REL_ON       = (EN_REL == "TRUE");

    pmcd_state_t        state_q;
    pmcd_state_t        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               lock_s;
    logic               fb_s;
    logic               fb_q;
    logic               fb_edge;
    logic               first_edge_q;
    logic               second_edge;
    logic               state_change;

    pmcd_release_ctrl_sync2 u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (dcm_locked),
        .q   (lock_s)
    );

    pmcd_release_ctrl_sync2 u_sync_fb (
        .clk (clk),
        .rst (rst),
        .d   (fb_div),
        .q   (fb_s)
    );

    // Both feedback edges count, so a divided clock proves itself in one period.
    assign fb_edge      = fb_s ^ fb_q;
    assign second_edge  = fb_edge && first_edge_q;
    assign state_change = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!lock_s)                   state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_REL_WAIT;
            end
            ST_REL_WAIT: begin
                if (!lock_s)                state_d = ST_HOLD;
                else if (cnt_q == REL_LAST) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Lock loss outranks everything; a late 2nd edge still beats the timeout.
                if (!lock_s) begin
                    state_d = ST_HOLD;
                end else if (second_edge) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q + RETRY_W'(1) == RETRY_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_HOLD;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_HOLD;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            fb_q         <= 1'b0;
            first_edge_q <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            fb_q    <= fb_s;
            // Saturate rather than wrap in the untimed states (WAIT_LOCK, RUN, FAULT).
            if (state_change)         cnt_q <= '0;
            else if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
            if (state_change || state_q != ST_CHECK) first_edge_q <= 1'b0;
            else if (fb_edge)                        first_edge_q <= 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            pmcd_rst <= 1'b1;
            pmcd_rel <= 1'b0;
            ready    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            pmcd_rst <= (state_d == ST_HOLD) || (state_d == ST_WAIT_LOCK) ||
                        (state_d == ST_STABLE) || (state_d == ST_FAULT);
            pmcd_rel <= REL_ON && ((state_d == ST_CHECK) || (state_d == ST_RUN));
            ready    <= (state_d == ST_RUN);
            fault    <= (state_d == ST_FAULT);
        end
    end

    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule
